mul_add: RTL and testbench
==========================

MUL_ADD -- requirements
Module: mul_add

Interface
REQ-001 Parameter: BIT_DEPTH, default 32, operand width in bits; SHALL be >= 2.
REQ-002 Port: clk  input  1  single clock; all state SHALL change only on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  level request; SHALL be sampled only in IDLE and DONE.
REQ-005 Port: multiplicand_in  input  BIT_DEPTH  unsigned operand A.
REQ-006 Port: multiplier_in  input  BIT_DEPTH  unsigned operand B.
REQ-007 Port: addend_in  input  BIT_DEPTH  unsigned operand C.
REQ-008 Port: done  output  1  high while result valid (DONE state).
REQ-009 Port: product  output  2*BIT_DEPTH  registered result A*B+C.

Function
REQ-010 The block SHALL compute product = A*B + C, all unsigned; result SHALL be exact in 2*BIT_DEPTH bits (max (2^N-1)^2+(2^N-1) < 2^2N, no overflow).
REQ-011 Algorithm SHALL be iterative shift-and-add, one multiplier bit per BUSY cycle, LSB first; no combinational N×N multiplier.
REQ-012 States SHALL be IDLE, BUSY, DONE; encoding free.
REQ-013 IDLE: start=1 at edge T -> capture A, B, C into internal registers, accumulator = zero-extended C, bit counter = 0, go BUSY; start=0 -> stay IDLE.
REQ-014 BUSY: each edge, if current multiplier bit = 1 add shifted multiplicand to accumulator; shift; counter +1.
REQ-015 BUSY SHALL last exactly BIT_DEPTH edges (T+1 .. T+BIT_DEPTH); at edge T+BIT_DEPTH product loads final accumulator, done -> 1, state -> DONE.
REQ-016 Latency: done SHALL be first observed high after edge T+BIT_DEPTH (BIT_DEPTH cycles after capture edge).
REQ-017 Inputs A, B, C and start SHALL be ignored during BUSY; changing them SHALL NOT affect the result.
REQ-018 DONE: start=1 -> remain DONE, done and product held; start=0 -> IDLE at next edge, done -> 0.
REQ-019 done SHALL be high for at least one cycle per operation; a new operation SHALL require start low for at least one edge (no re-trigger while start held high).
REQ-020 product SHALL hold its last value in IDLE and BUSY until overwritten at the next completion.
REQ-021 B = 0 or A = 0 SHALL still take full BIT_DEPTH cycles and yield product = C.
REQ-022 done SHALL depend only on state (Moore); no combinational path from inputs to outputs.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, done=0, product=0, accumulator and counter=0, regardless of state; reset SHALL take priority over start.
REQ-024 reset asserted mid-BUSY SHALL abort the operation; done SHALL NOT assert for the aborted operation.
REQ-025 With reset and start both low after reset, outputs SHALL stay at reset values.

Verification
REQ-026 A=25, B=4, C=0, start held high -> done after 32 cycles, product=100; held while start high.
REQ-027 A=22, B=56, C=2 -> product=1234; A=257, B=255, C=0 -> product=65535 (inverse of division cases).
REQ-028 A=B=C=0xFFFFFFFF -> product=0xFFFFFFFF_00000000, done exactly 32 cycles after capture.
REQ-029 A=100, B=0, C=7 -> product=7 after full 32 cycles; then A=0, B=100, C=0 -> product=0.
REQ-030 Start op A=3, B=5, C=1; change inputs to A=9, B=9, C=9 at cycle 5 -> product=16 unaffected.
REQ-031 Reset pulsed at BUSY cycle 10 -> done never asserts, product=0, IDLE; next op A=6, B=7, C=0 -> product=42.

Source files
------------

// File: rtl/mul_add_if.sv
// Operand/result bundle for the iterative multiply-add unit.
// The master drives the operands and start; the slave returns done and product.
interface mul_add_if #(
  parameter int BIT_DEPTH = 32
);
  logic                     start;
  logic [BIT_DEPTH-1:0]     multiplicand_in;
  logic [BIT_DEPTH-1:0]     multiplier_in;
  logic [BIT_DEPTH-1:0]     addend_in;
  logic                     done;
  logic [2*BIT_DEPTH-1:0]   product;

  modport master (
    output start, multiplicand_in, multiplier_in, addend_in,
    input  done, product
  );

  modport slave (
    input  start, multiplicand_in, multiplier_in, addend_in,
    output done, product
  );
endinterface

// File: rtl/mul_add.sv
// Unsigned A*B+C by LSB-first shift-and-add, one multiplier bit per cycle.
// Latency: done rises BIT_DEPTH cycles after the capture edge; result holds while start stays high.
module mul_add #(
  parameter int BIT_DEPTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  mul_add_if.slave bus
);
  localparam int CW = $clog2(BIT_DEPTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]             r_state;
  logic [2*BIT_DEPTH-1:0] r_mcand;
  logic [BIT_DEPTH-1:0]   r_mplier;
  logic [2*BIT_DEPTH-1:0] r_acc;
  logic [2*BIT_DEPTH-1:0] r_product;
  logic [CW-1:0]          r_cnt;

  logic [2*BIT_DEPTH-1:0] w_sum;
  logic                   w_last;

  // Accumulator starts at C, so the final sum is exact in 2*BIT_DEPTH bits.
  assign w_sum  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last = (r_cnt == CW'(BIT_DEPTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_mcand  <= {{BIT_DEPTH{1'b0}}, bus.multiplicand_in};
            r_mplier <= bus.multiplier_in;
            r_acc    <= {{BIT_DEPTH{1'b0}}, bus.addend_in};
            r_cnt    <= '0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= w_sum;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= w_sum;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          // Start must drop before another operation can be accepted.
          if (!bus.start) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.done    = (r_state == S_DONE);
  assign bus.product = r_product;
endmodule

// File: tb/tb_mul_add.sv
// Directed-vector bench for mul_add at BIT_DEPTH=32.
module tb_mul_add;
  localparam int N = 32;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [N-1:0]   c;
    logic [2*N-1:0] exp;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [2*N-1:0] prev_product;

  mul_add_if #(.BIT_DEPTH(N)) bus ();

  mul_add #(.BIT_DEPTH(N)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Runs one operation with start held high through BUSY and one DONE cycle.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] c, input logic [2*N-1:0] exp);
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand_in = a;
    bus.multiplier_in = b;
    bus.addend_in = c;
    @(posedge clk); #1;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) check("busy_product_hold", bus.product, prev_product);
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check("latency", 64'(lat), 64'(N));
    check("product", bus.product, exp);
    @(posedge clk); #1;
    check("done_held", 64'(bus.done), 64'd1);
    check("product_held", bus.product, exp);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("done_clear", 64'(bus.done), 64'd0);
    check("idle_product_hold", bus.product, exp);
    prev_product = exp;
  endtask

  vec_t vecs[8];

  initial begin
    int lat;
    int done_seen;

    vecs[0] = '{a: 32'd25,         b: 32'd4,          c: 32'd0,          exp: 64'd100};
    vecs[1] = '{a: 32'd22,         b: 32'd56,         c: 32'd2,          exp: 64'd1234};
    vecs[2] = '{a: 32'd257,        b: 32'd255,        c: 32'd0,          exp: 64'd65535};
    vecs[3] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  c: 32'hFFFF_FFFF,  exp: 64'hFFFF_FFFF_0000_0000};
    vecs[4] = '{a: 32'd100,        b: 32'd0,          c: 32'd7,          exp: 64'd7};
    vecs[5] = '{a: 32'd0,          b: 32'd100,        c: 32'd0,          exp: 64'd0};
    vecs[6] = '{a: 32'd12345,      b: 32'd6789,       c: 32'd1000,       exp: 64'd83811205};
    vecs[7] = '{a: 32'hFFFF_FFFF,  b: 32'd2,          c: 32'd1,          exp: 64'h1_FFFF_FFFF};

    checks = 0;
    failures = 0;
    prev_product = '0;
    reset = 1'b1;
    bus.start = 1'b1;
    bus.multiplicand_in = 32'd5;
    bus.multiplier_in = 32'd5;
    bus.addend_in = 32'd5;
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_product", bus.product, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("idle_done", 64'(bus.done), 64'd0);
    check("idle_product", bus.product, 64'd0);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp);

    // Operand changes during BUSY must not disturb the result.
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand_in = 32'd3;
    bus.multiplier_in = 32'd5;
    bus.addend_in = 32'd1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin
        bus.multiplicand_in = 32'd9;
        bus.multiplier_in = 32'd9;
        bus.addend_in = 32'd9;
        bus.start = 1'b1;
      end
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    check("change_latency", 64'(lat), 64'(N));
    check("change_product", bus.product, 64'd16);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("change_done_clear", 64'(bus.done), 64'd0);

    // Reset mid-BUSY aborts the operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand_in = 32'd25;
    bus.multiplier_in = 32'd4;
    bus.addend_in = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_product", bus.product, 64'd0);
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    check("abort_product_idle", bus.product, 64'd0);
    prev_product = '0;
    run_op(32'd6, 32'd7, 32'd0, 64'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
